// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: buffered entry layout,
// fetch FSM states and a saturating adder for the optional perf counters.
package fetch_pkg;

  localparam logic [31:0] INST_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of fetch entries with a synchronous flush; the head entry
// is visible combinationally whenever the FIFO is not empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           din,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fetch_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_COUNT);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // Flush beats any push or pop arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  overflow_check: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full && !(pop && !empty)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited BRAM requests, epoch-tagged
// in-flight tracker, output FIFO and redirect flush. FETCH_PERF_EN adds counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_LAT    = 2,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_read_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_q,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded,
  output logic [31:0] perf_stall_cyc
`endif
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW:0] DEPTH_C = (FCW + 1)'(FIFO_DEPTH);

  fetch_state_e   state_reg;
  logic [31:0]    pc_reg;
  logic           epoch_reg;
  logic           trk_valid_reg [MEM_LAT];
  logic [31:0]    trk_pc_reg    [MEM_LAT];
  logic           trk_epoch_reg [MEM_LAT];

  logic [FCW:0]   in_flight;
  logic [FCW:0]   occupancy;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           credit_ok;
  logic           issue;
  logic           resp_valid;
  logic           resp_keep;
  logic           fifo_pop;
  fetch_entry_t   fifo_din;
  fetch_entry_t   fifo_head;
  logic           unused_pc_bits;

  assign unused_pc_bits = &{1'b0, redirect_pc[1:0]};

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      in_flight = in_flight + (FCW + 1)'(trk_valid_reg[i]);
    end
  end

  // Requests in flight plus buffered words reserve FIFO slots, so a push never finds it full.
  assign occupancy   = in_flight + {1'b0, fifo_count};
  assign credit_ok   = !fifo_full && (occupancy < DEPTH_C);
  assign issue       = (state_reg == S_RUN) && !redirect_valid && credit_ok;
  assign mem_read_en = issue;
  assign mem_addr    = pc_reg;

  assign resp_valid = trk_valid_reg[MEM_LAT-1];
  assign resp_keep  = resp_valid && (trk_epoch_reg[MEM_LAT-1] == epoch_reg) && !redirect_valid;
  assign fifo_din   = '{pc: trk_pc_reg[MEM_LAT-1], inst: mem_q};
  assign fifo_pop   = inst_valid && !stall && !redirect_valid;

  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? fifo_head.inst : '0;
  assign inst_pc    = inst_valid ? fifo_head.pc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_BOOT;
      pc_reg    <= RESET_PC;
      epoch_reg <= 1'b0;
    end else if (redirect_valid) begin
      state_reg <= S_REDIR;
      pc_reg    <= {redirect_pc[31:2], 2'b00};
      epoch_reg <= ~epoch_reg;
    end else begin
      case (state_reg)
        S_BOOT:  state_reg <= S_RUN;
        S_REDIR: state_reg <= S_RUN;
        S_RUN: begin
          if (issue) pc_reg <= pc_reg + INST_BYTES;
        end
        default: state_reg <= S_BOOT;
      endcase
    end
  end

  // The tracker shifts unconditionally so its last stage lines up with mem_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        trk_valid_reg[i] <= 1'b0;
        trk_pc_reg[i]    <= '0;
        trk_epoch_reg[i] <= 1'b0;
      end
    end else begin
      trk_valid_reg[0] <= issue;
      trk_pc_reg[0]    <= pc_reg;
      trk_epoch_reg[0] <= epoch_reg;
      for (int i = 1; i < MEM_LAT; i++) begin
        trk_valid_reg[i] <= trk_valid_reg[i-1];
        trk_pc_reg[i]    <= trk_pc_reg[i-1];
        trk_epoch_reg[i] <= trk_epoch_reg[i-1];
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (resp_keep),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_reg;
  logic [31:0] discarded_reg;
  logic [31:0] stall_cyc_reg;
  logic [31:0] discard_inc;

  // Discards are stale or redirect-cycle responses plus whatever the flush throws away.
  always_comb begin
    discard_inc = '0;
    if (resp_valid && !resp_keep) discard_inc = discard_inc + 32'd1;
    if (redirect_valid)           discard_inc = discard_inc + 32'(fifo_count);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_reg   <= '0;
      discarded_reg <= '0;
      stall_cyc_reg <= '0;
    end else begin
      if (resp_keep)          fetched_reg   <= sat_add(fetched_reg, 32'd1);
      discarded_reg <= sat_add(discarded_reg, discard_inc);
      if (inst_valid && stall) stall_cyc_reg <= sat_add(stall_cyc_reg, 32'd1);
    end
  end

  assign perf_fetched   = fetched_reg;
  assign perf_discarded = discarded_reg;
  assign perf_stall_cyc = stall_cyc_reg;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 2-cycle BRAM model holding
// mem[i] = 32'hA000_0000 + i.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_q = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;
  logic [31:0] perf_stall_cyc;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_pc;
  logic [31:0] bram_s1 = '0;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_read_en    (mem_read_en),
    .mem_addr       (mem_addr),
    .mem_q          (mem_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  // BRAM: 2-cycle read latency, zero when no read was issued.
  always @(posedge clk) begin
    bram_s1 <= mem_read_en ? mem_word(mem_addr) : '0;
    mem_q   <= bram_s1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic expect_stream(input int n);
    for (int k = 0; k < n; k++) begin
      check_eq("stream_valid", 32'(inst_valid), 32'd1);
      check_eq("stream_pc", inst_pc, exp_pc);
      check_eq("stream_inst", inst, mem_word(exp_pc));
      $display("inst pc=%h inst=%h", inst_pc, inst);
      exp_pc = exp_pc + 32'd4;
      tick();
    end
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!inst_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({tag, "_valid"}, 32'(inst_valid), 32'd1);
    if (exp_lat >= 0) check_eq({tag, "_cycles"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int issues;
    int lat;
    rst_n = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #2 rst_n = 1'b0;
    repeat (3) tick();

    check_eq("rst_read_en", 32'(mem_read_en), 32'd0);
    check_eq("rst_addr", mem_addr, 32'h0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_inst_pc", inst_pc, 32'h0);

    // 1: reset release, free-running stream
    rst_n = 1'b1;
    wait_valid("t1_first", 4);
    exp_pc = 32'h0;
    expect_stream(8);

    // 2: stall for 10 cycles, then release with no gap
    stall = 1'b1;
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_read_en) issues++;
      check_eq("t2_frozen_pc", inst_pc, exp_pc);
      tick();
    end
    check_eq("t2_frozen_inst", inst, mem_word(exp_pc));
    check_eq("t2_issues_le4", 32'(issues <= 4), 32'd1);
    $display("stall window issues=%0d", issues);
    stall = 1'b0;
    expect_stream(8);

    // 3: redirect to 0x40 mid-stream
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    check_eq("t3_no_issue_redirect", 32'(mem_read_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    check_eq("t3_valid_dropped", 32'(inst_valid), 32'd0);
    wait_valid("t3_resume", -1);
    exp_pc = 32'h40;
    expect_stream(4);

    // 4: unaligned redirect with stall held
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    tick();
    redirect_valid = 1'b0;
    stall = 1'b0;
    check_eq("t4_valid_dropped", 32'(inst_valid), 32'd0);
    wait_valid("t4_resume", -1);
    exp_pc = 32'h40;
    expect_stream(4);

    // 5: PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    lat = 0;
    while (!mem_read_en && lat < 10) begin
      tick();
      lat++;
    end
    check_eq("t5_issue_seen", 32'(mem_read_en), 32'd1);
    check_eq("t5_first_addr", mem_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("t5_wrap_issue", 32'(mem_read_en), 32'd1);
    check_eq("t5_wrap_addr", mem_addr, 32'h0);
    wait_valid("t5_resume", -1);
    exp_pc = 32'hFFFF_FFFC;
    expect_stream(4);

    // 6: short async reset pulse with reads in flight
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid_now", 32'(inst_valid), 32'd0);
    check_eq("t6_read_en_now", 32'(mem_read_en), 32'd0);
    check_eq("t6_addr_now", mem_addr, 32'h0);
    check_eq("t6_inst_pc_now", inst_pc, 32'h0);
    #1;
    rst_n = 1'b1;
    wait_valid("t6_restart", 4);
    exp_pc = 32'h0;
    expect_stream(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
